// File: rtl/lsu_byte_sequencer.sv
// Load/store sequencer: serialises one RV32 load or store into 1, 2 or 4
// big-endian byte accesses on a byte-wide memory and returns a 32-bit result.
module lsu_byte_sequencer #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_wdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic                  resp_err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_last;
  logic [ADDR_WIDTH-1:0] r_base;
  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_asm;
  logic                  r_req_ready;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_we;
  logic [BYTE_W-1:0]     r_mem_wdata;
  logic                  r_resp_valid;
  logic [DATA_W-1:0]     r_resp_data;
  logic                  r_resp_err;

  logic                  w_req_fire;
  logic                  w_req_legal;
  logic [CNT_W-1:0]      w_req_last;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_cnt_done;
  logic [DATA_W-1:0]     w_asm_next;
  logic [DATA_W-1:0]     w_load_result;

  // Byte idx of an (last+1)-byte right-aligned field, most significant first.
  function automatic logic [BYTE_W-1:0] f_store_byte(
    input logic [DATA_W-1:0] data,
    input logic [CNT_W-1:0]  last,
    input logic [CNT_W-1:0]  idx
  );
    logic [CNT_W-1:0] lane;
    lane = CNT_W'(last - idx);
    return data[{lane, 3'b000} +: BYTE_W];
  endfunction

  // Request decode: legality and last byte index for the access size.
  always_comb begin
    w_req_fire  = req_valid && r_req_ready;
    w_req_legal = 1'b0;
    w_req_last  = '0;
    if (req_we) begin
      w_req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                    (req_funct3 == 3'b010);
    end else begin
      w_req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                    (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                    (req_funct3 == 3'b101);
    end
    case (req_funct3[1:0])
      2'b00:   w_req_last = CNT_W'(0);
      2'b01:   w_req_last = CNT_W'(1);
      2'b10:   w_req_last = CNT_W'(3);
      default: w_req_last = CNT_W'(0);
    endcase
  end

  // Byte counter step and load assembly including the byte on the bus now.
  always_comb begin
    w_cnt_inc  = CNT_W'(r_cnt + CNT_W'(1));
    w_cnt_done = (r_cnt == r_last);
    w_asm_next = {r_asm[DATA_W-BYTE_W-1:0], mem_rdata};
  end

  // Sign/zero extension of the completed load.
  always_comb begin
    w_load_result = w_asm_next;
    case (r_funct3)
      3'b000:  w_load_result = {{24{w_asm_next[7]}}, w_asm_next[7:0]};
      3'b001:  w_load_result = {{16{w_asm_next[15]}}, w_asm_next[15:0]};
      3'b100:  w_load_result = {24'h0, w_asm_next[7:0]};
      3'b101:  w_load_result = {16'h0, w_asm_next[15:0]};
      default: w_load_result = w_asm_next;
    endcase
  end

  // Sequencer FSM with registered memory and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last       <= '0;
      r_base       <= '0;
      r_we         <= 1'b0;
      r_funct3     <= '0;
      r_wdata      <= '0;
      r_asm        <= '0;
      r_req_ready  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_wdata  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_req_fire) begin
            r_req_ready <= 1'b0;
            r_base      <= req_addr;
            r_we        <= req_we;
            r_funct3    <= req_funct3;
            r_wdata     <= req_wdata;
            r_last      <= w_req_last;
            r_cnt       <= '0;
            r_asm       <= '0;
            if (w_req_legal) begin
              r_state     <= S_ACCESS;
              r_mem_addr  <= req_addr;
              r_mem_we    <= req_we;
              r_mem_wdata <= req_we ? f_store_byte(req_wdata, w_req_last, '0) : '0;
            end else begin
              // Illegal size code: respond with an error, no memory traffic.
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_data  <= '0;
            end
          end
        end

        S_ACCESS: begin
          if (!r_we) begin
            r_asm <= w_asm_next;
          end
          if (w_cnt_done) begin
            r_state      <= S_RESP;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_data  <= r_we ? '0 : w_load_result;
          end else begin
            r_cnt       <= w_cnt_inc;
            r_mem_addr  <= r_base + ADDR_WIDTH'(w_cnt_inc);
            r_mem_wdata <= r_we ? f_store_byte(r_wdata, r_last, w_cnt_inc) : '0;
          end
        end

        S_RESP: begin
          if (resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_data  <= '0;
            r_req_ready  <= 1'b1;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_mem_we    <= 1'b0;
          r_mem_wdata <= '0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign mem_addr   = r_mem_addr;
  assign mem_we     = r_mem_we;
  assign mem_wdata  = r_mem_wdata;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Bench for lsu_byte_sequencer: directed scenarios plus random transactions
// checked against a byte-array memory model.
module tb_lsu_byte_sequencer;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_wdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_data;
  logic          resp_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Environment memory (256 bytes, aliased on the low address byte).
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  int         n_writes = 0;
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr = '0;
  logic [7:0] pl_data = '0;

  always #5 clk = ~clk;

  lsu_byte_sequencer #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  assign mem_rdata = mem[mem_addr[7:0]];

  // Memory write port plus bench preload path.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (rst_n && mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
      n_writes <= n_writes + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Number of bytes for a request, 0 when the code is illegal.
  function automatic int nbytes(input logic we, input logic [2:0] f3);
    if (we) begin
      case (f3)
        3'b000: return 1;
        3'b001: return 2;
        3'b010: return 4;
        default: return 0;
      endcase
    end
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  // Big-endian load value, sign-extended for LB/LH.
  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
    int     n;
    longint v;
    logic [31:0] a;
    n = nbytes(1'b0, f3);
    v = 0;
    for (int k = 0; k < n; k++) begin
      a = addr + 32'(k);
      v = v * 256 + longint'(ref_mem[a[7:0]]);
    end
    if (f3[2] == 1'b0 && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [2:0] f3,
                         input logic [31:0] wd, input int hold);
    int          n;
    int          exp_lat;
    int          lat;
    int          we_cnt;
    int          w0;
    logic [31:0] exp_data;
    logic [31:0] seen [$];
    logic [31:0] a;
    logic [31:0] held;
    n       = nbytes(we, f3);
    exp_lat = (n == 0) ? 1 : n + 1;
    exp_data = (we || n == 0) ? 32'h0 : model_load(addr, f3);
    lat    = 0;
    we_cnt = 0;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_we     = we;
    req_funct3 = f3;
    req_wdata  = wd;
    resp_ready = 1'b0;
    w0 = n_writes;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c;
        break;
      end
      seen.push_back(mem_addr);
      we_cnt += int'(mem_we);
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    for (int k = 0; k < n; k++) begin
      a = (k < seen.size()) ? seen[k] : 32'hDEADBEEF;
      chk("mem_addr", a, addr + 32'(k));
    end
    chk("mem_we_cycles", 32'(we_cnt), we ? 32'(n) : 32'd0);
    chk("resp_err", 32'(resp_err), (n == 0) ? 32'd1 : 32'd0);
    chk("resp_data", resp_data, exp_data);
    held = resp_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_data", resp_data, held);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("resp_valid_drop", 32'(resp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
    if (we && n > 0) begin
      for (int k = 0; k < n; k++) begin
        a = addr + 32'(k);
        ref_mem[a[7:0]] = 8'(wd >> (8 * (n - 1 - k)));
      end
    end
    chk("write_count", 32'(n_writes - w0), we ? 32'(n) : 32'd0);
    for (int k = -1; k <= 4; k++) begin
      a = addr + 32'(k);
      chk("mem_byte", 32'(mem[a[7:0]]), 32'(ref_mem[a[7:0]]));
    end
  endtask

  task automatic reset_mid_store();
    int w0;
    logic [31:0] a;
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = 32'h40;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_wdata  = 32'h11223344;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst_byte1_we", 32'(mem_we), 32'd1);
    @(negedge clk);
    chk("rst_byte2_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_we_drop", 32'(mem_we), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    ref_mem[8'h40] = 8'h11;
    w0 = n_writes;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("post_rst_writes", 32'(n_writes - w0), 32'd0);
    for (int k = 0; k < 4; k++) begin
      a = 32'h40 + 32'(k);
      chk("post_rst_mem", 32'(mem[a[7:0]]), 32'(ref_mem[a[7:0]]));
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_we     = 1'b0;
    req_funct3 = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_data", resp_data, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);

    for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));
    preload(8'h10, 8'h80);
    preload(8'h11, 8'h12);
    preload(8'h12, 8'h34);
    preload(8'h13, 8'h56);
    chk("reset_held_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_txn(32'h10, 1'b0, 3'b010, 32'h0, 0);
    chk("lw_value", model_load(32'h10, 3'b010), 32'h80123456);
    run_txn(32'h10, 1'b0, 3'b000, 32'h0, 0);
    run_txn(32'h10, 1'b0, 3'b100, 32'h0, 0);
    run_txn(32'h11, 1'b0, 3'b001, 32'h0, 1);
    run_txn(32'h10, 1'b0, 3'b101, 32'h0, 0);
    run_txn(32'h20, 1'b1, 3'b001, 32'hAABBCCDD, 0);
    chk("sh_byte0", 32'(mem[8'h20]), 32'hCC);
    chk("sh_byte1", 32'(mem[8'h21]), 32'hDD);
    run_txn(32'hFFFFFFFE, 1'b0, 3'b010, 32'h0, 0);
    run_txn(32'h30, 1'b1, 3'b011, 32'h12345678, 0);
    run_txn(32'h10, 1'b0, 3'b010, 32'h0, 3);
    reset_mid_store();

    for (int t = 0; t < 80; t++) begin
      run_txn($urandom, 1'($urandom), 3'($urandom), $urandom, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
